clock_timekeeper: RTL and testbench

Timekeeping and alarm core for the classic VGA clock. It counts 12-hour time from a 1 Hz tick and applies the debounced adjustment pulses. It also holds the alarm setpoint, runs the alarm state machine and gates the buzzer tone. Its outputs drive the clock-face renderer (time, alarm time, alarm-armed bell symbol) and the external buzzer driver.

---
 rtl/clock_timekeeper.sv | 163 ++++++++++++++++
 tb/tb_clock_timekeeper.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_timekeeper.sv
// Timekeeping and alarm core for the VGA clock: 12-hour time from a 1 Hz tick,
// debounced adjusts with deferred-tick handling, alarm setpoint, alarm FSM and buzzer gate.
module clock_timekeeper #(
  parameter int RING_SECS = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       sec_adj,
  input  logic       min_adj,
  input  logic       hrs_adj,
  input  logic       al_adj,
  input  logic       al_toggle,
  input  logic       buzzer_tone,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [3:0] hours,
  output logic [5:0] al_minutes,
  output logic [3:0] al_hours,
  output logic       al_on,
  output logic       alarm,
  output logic       buzzer_out
);

  // Bit 0 is the bell symbol, bit 1 is ringing, so both outputs come straight off flops.
  typedef enum logic [1:0] {
    OFF     = 2'b00,
    ARMED   = 2'b01,
    RINGING = 2'b11
  } alarm_state_t;

  localparam logic [5:0] RING_LOAD = 6'(RING_SECS);

  alarm_state_t r_state;
  alarm_state_t w_stateNext;

  logic [5:0] r_sec;
  logic [5:0] r_min;
  logic [3:0] r_hrs;
  logic [5:0] r_alMin;
  logic [3:0] r_alHrs;
  logic       r_pend;
  logic       r_beat;
  logic [5:0] r_ringCnt;
  logic       r_buzzer;

  logic       w_anyAdj;
  logic       w_applyTick;
  logic       w_pendNext;
  logic       w_match;
  logic [5:0] w_secNext;
  logic [5:0] w_minNext;
  logic [3:0] w_hrsNext;
  logic [5:0] w_alMinNext;
  logic [3:0] w_alHrsNext;
  logic [5:0] w_ringNext;

  assign w_anyAdj    = sec_adj | min_adj | hrs_adj;
  assign w_applyTick = ~w_anyAdj & (sec_tick | r_pend);
  assign w_pendNext  = w_anyAdj & (r_pend | sec_tick);
  assign w_match     = (r_hrs == r_alHrs) && (r_min == r_alMin) && (r_sec == 6'd0);

  // A tick (fresh or pending) never coincides with an adjust, so the two paths are exclusive.
  always_comb begin
    w_secNext = r_sec;
    w_minNext = r_min;
    w_hrsNext = r_hrs;
    if (w_applyTick) begin
      if (r_sec == 6'd59) begin
        w_secNext = 6'd0;
        if (r_min == 6'd59) begin
          w_minNext = 6'd0;
          w_hrsNext = (r_hrs == 4'd11) ? 4'd0 : r_hrs + 4'd1;
        end else begin
          w_minNext = r_min + 6'd1;
        end
      end else begin
        w_secNext = r_sec + 6'd1;
      end
    end else begin
      if (sec_adj) w_secNext = (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
      if (min_adj) w_minNext = (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
      if (hrs_adj) w_hrsNext = (r_hrs == 4'd11) ? 4'd0 : r_hrs + 4'd1;
    end
  end

  always_comb begin
    w_alMinNext = r_alMin;
    w_alHrsNext = r_alHrs;
    if (al_adj) begin
      if (r_alMin == 6'd50) begin
        w_alMinNext = 6'd0;
        w_alHrsNext = (r_alHrs == 4'd11) ? 4'd0 : r_alHrs + 4'd1;
      end else begin
        w_alMinNext = r_alMin + 6'd10;
      end
    end
  end

  // The toggle always wins over both the match and the ring timeout.
  always_comb begin
    w_stateNext = r_state;
    w_ringNext  = r_ringCnt;
    unique case (r_state)
      OFF: begin
        if (al_toggle) w_stateNext = ARMED;
      end
      ARMED: begin
        if (al_toggle) begin
          w_stateNext = OFF;
        end else if (w_match) begin
          w_stateNext = RINGING;
          w_ringNext  = RING_LOAD;
        end
      end
      RINGING: begin
        if (al_toggle) begin
          w_stateNext = OFF;
        end else if (w_applyTick) begin
          w_ringNext = r_ringCnt - 6'd1;
          if (r_ringCnt <= 6'd1) w_stateNext = ARMED;
        end
      end
      default: w_stateNext = OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= OFF;
      r_sec     <= 6'd0;
      r_min     <= 6'd0;
      r_hrs     <= 4'd0;
      r_alMin   <= 6'd0;
      r_alHrs   <= 4'd0;
      r_pend    <= 1'b0;
      r_beat    <= 1'b0;
      r_ringCnt <= 6'd0;
      r_buzzer  <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_sec     <= w_secNext;
      r_min     <= w_minNext;
      r_hrs     <= w_hrsNext;
      r_alMin   <= w_alMinNext;
      r_alHrs   <= w_alHrsNext;
      r_pend    <= w_pendNext;
      r_beat    <= r_beat ^ w_applyTick;
      r_ringCnt <= w_ringNext;
      r_buzzer  <= (r_state == RINGING) & r_beat & buzzer_tone;
    end
  end

  assign seconds    = r_sec;
  assign minutes    = r_min;
  assign hours      = r_hrs;
  assign al_minutes = r_alMin;
  assign al_hours   = r_alHrs;
  assign al_on      = r_state[0];
  assign alarm      = r_state[1];
  assign buzzer_out = r_buzzer;

endmodule

// File: tb/tb_clock_timekeeper.sv
// Scoreboard bench for clock_timekeeper: a seconds-of-day / alarm-slot model predicts
// every cycle's outputs, a monitor compares them one cycle after the stimulus.
module tb_clock_timekeeper;
  localparam int RING = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sec_tick = 1'b0, sec_adj = 1'b0, min_adj = 1'b0, hrs_adj = 1'b0;
  logic       al_adj = 1'b0, al_toggle = 1'b0, buzzer_tone = 1'b0;
  logic [5:0] seconds, minutes, al_minutes;
  logic [3:0] hours, al_hours;
  logic       al_on, alarm, buzzer_out;

  int checks = 0;
  int errors = 0;
  int cycleNo = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycleNo <= cycleNo + 1;

  clock_timekeeper #(.RING_SECS(RING)) dut (
    .clk(clk), .reset(reset), .sec_tick(sec_tick), .sec_adj(sec_adj),
    .min_adj(min_adj), .hrs_adj(hrs_adj), .al_adj(al_adj), .al_toggle(al_toggle),
    .buzzer_tone(buzzer_tone), .seconds(seconds), .minutes(minutes), .hours(hours),
    .al_minutes(al_minutes), .al_hours(al_hours), .al_on(al_on), .alarm(alarm),
    .buzzer_out(buzzer_out)
  );

  typedef struct {
    int due;
    int sec, mins, hrs, alMin, alHrs, alOn, alarmV, buz;
  } exp_t;
  exp_t sbq[$];

  // Model: time as seconds into the 12-hour dial, alarm as one of 72 ten-minute slots.
  int mT = 0, mAl = 0, mState = 0, mRing = 0, mPend = 0, mBeat = 0, mBuz = 0;

  task automatic modelStep(input bit rst, tk, sa, ma, ha, aa, tg, tone);
    int s, m, h;
    bit anyAdj, applied, match;
    if (rst) begin
      mT = 0; mAl = 0; mState = 0; mRing = 0; mPend = 0; mBeat = 0; mBuz = 0;
      return;
    end
    s = mT % 60;
    m = (mT / 60) % 60;
    h = mT / 3600;
    anyAdj  = sa | ma | ha;
    applied = !anyAdj && (tk || mPend != 0);
    match   = (h == mAl / 6) && (m == (mAl % 6) * 10) && (s == 0);
    mBuz    = (mState == 2 && mBeat != 0 && tone) ? 1 : 0;
    case (mState)
      0: if (tg) mState = 1;
      1: begin
        if (tg) mState = 0;
        else if (match) begin mState = 2; mRing = RING; end
      end
      default: begin
        if (tg) mState = 0;
        else if (applied) begin
          mRing = mRing - 1;
          if (mRing == 0) mState = 1;
        end
      end
    endcase
    if (applied) mT = (mT + 1) % 43200;
    else begin
      if (sa) s = (s + 1) % 60;
      if (ma) m = (m + 1) % 60;
      if (ha) h = (h + 1) % 12;
      mT = h * 3600 + m * 60 + s;
    end
    mPend = anyAdj ? ((mPend != 0 || tk) ? 1 : 0) : 0;
    if (applied) mBeat = 1 - mBeat;
    if (aa) mAl = (mAl + 1) % 72;
  endtask

  task automatic applyStimulus(input bit rst, tk, sa, ma, ha, aa, tg, tone);
    exp_t e;
    reset = rst; sec_tick = tk; sec_adj = sa; min_adj = ma; hrs_adj = ha;
    al_adj = aa; al_toggle = tg; buzzer_tone = tone;
    modelStep(rst, tk, sa, ma, ha, aa, tg, tone);
    e.due = cycleNo + 1;
    e.sec = mT % 60; e.mins = (mT / 60) % 60; e.hrs = mT / 3600;
    e.alMin = (mAl % 6) * 10; e.alHrs = mAl / 6;
    e.alOn = (mState != 0) ? 1 : 0; e.alarmV = (mState == 2) ? 1 : 0; e.buz = mBuz;
    sbq.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit tk, sa, ma, ha, aa, tg);
    applyStimulus(1'b0, tk, sa, ma, ha, aa, tg, 1'($urandom_range(0, 1)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Alarm 1:10 armed, time 1:09:59, then one tick so the match fires.
  task automatic setupRinging();
    doReset();
    for (int i = 0; i < 7; i++) drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 59; i++) drive(0, 1, i < 9, i == 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    idle(4);
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (seconds !== 6'(e.sec) || minutes !== 6'(e.mins) || hours !== 4'(e.hrs) ||
        al_minutes !== 6'(e.alMin) || al_hours !== 4'(e.alHrs) || al_on !== 1'(e.alOn) ||
        alarm !== 1'(e.alarmV) || buzzer_out !== 1'(e.buz)) begin
      errors++;
      $display("[TB] FAIL outputs@cycle%0d: got %0d:%0d:%0d al %0d:%0d on=%b alarm=%b buz=%b, expected %0d:%0d:%0d al %0d:%0d on=%0d alarm=%0d buz=%0d",
               e.due, hours, minutes, seconds, al_hours, al_minutes, al_on, alarm, buzzer_out,
               e.hrs, e.mins, e.sec, e.alHrs, e.alMin, e.alOn, e.alarmV, e.buz);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].due <= cycleNo) begin
        e = sbq.pop_front();
        if (e.due == cycleNo) checkOutput(e);
        else begin
          checks++; errors++;
          $display("[TB] FAIL stale@cycle%0d: entry for cycle %0d never compared", cycleNo, e.due);
        end
      end
    end
  end

  initial begin : driver
    int waitCount;
    @(posedge clk); #1;
    doReset();
    for (int i = 0; i < 3661; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      idle(1);
    end
    for (int i = 0; i < 58; i++) drive(0, 1, 1, i < 10, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 30; i++) drive(0, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    idle(3);
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    idle(3);

    doReset();
    for (int i = 0; i < 7; i++) drive(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 64; i++) drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    idle(2);

    setupRinging();
    idle(10);
    for (int k = 0; k < 6; k++) begin
      drive(1, 0, 0, 0, 0, 0);
      idle(3);
    end

    setupRinging();
    idle(2);
    drive(1, 0, 0, 0, 0, 1);
    idle(3);

    setupRinging();
    applyStimulus(1, 1, 1, 1, 1, 1, 1, 1);
    idle(3);

    doReset();
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 499) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 31) == 0, 1'($urandom_range(0, 1)));
    end
    for (int r = 0; r < 4; r++) begin
      setupRinging();
      for (int i = 0; i < 40; i++)
        drive($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, 0, 0,
              $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
    end
    idle(2);

    waitCount = 0;
    while (sbq.size() > 0 && waitCount < 10) begin
      @(negedge clk);
      waitCount++;
    end
    if (sbq.size() > 0) begin
      checks++; errors++;
      $display("[TB] FAIL drain: %0d expected entries left, required 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
